// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_responder
// Description : Memory-side responder for a req/gnt/rvalid data or instruction
//               bus. Grants one request per cycle, performs byte-enabled
//               writes into a local word array and returns read data, write
//               acknowledges and bus errors after a fixed latency.
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned LATENCY     = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic        stall_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [6:0]  wdata_intg_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic [6:0]  rdata_intg_o,
  output logic        err_o
);

  // Index width; a one-word memory still needs a one-bit index.
  localparam int unsigned c_IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  logic [31:0]        r_mem [DEPTH_WORDS];

  logic               r_vld [LATENCY];
  logic               r_err [LATENCY];
  logic [31:0]        r_dat [LATENCY];

  logic               w_gnt;
  logic [29:0]        w_word_off;
  logic               w_in_range;
  logic [c_IDX_W-1:0] w_idx;
  logic [31:0]        w_rd_word;
  logic [31:0]        w_rsp_data;
  logic               w_unused;

  // Grant is purely combinational; reset blocks any acceptance.
  assign w_gnt = req_i & ~stall_i & ~RST;
  assign gnt_o = w_gnt;

  // Word offset is 30-bit unsigned; addresses below the base are rejected by
  // the explicit compare rather than being allowed to wrap into range.
  assign w_word_off = addr_i[31:2] - BASE_ADDR[31:2];
  assign w_in_range = (addr_i[31:2] >= BASE_ADDR[31:2]) &&
                      ({2'b00, w_word_off} < DEPTH_WORDS);
  assign w_idx      = w_word_off[c_IDX_W-1:0];

  // Reads see the array as of this edge, so a write granted on the previous
  // edge is already visible.
  assign w_rd_word  = r_mem[w_idx];
  assign w_rsp_data = (w_gnt && !we_i && w_in_range) ? w_rd_word : 32'h0000_0000;

  // Byte-enabled write into the array on a granted, in-range write.
  always_ff @(posedge CLK) begin
    if (w_gnt && we_i && w_in_range) begin
      for (int n = 0; n < 4; n++) begin
        if (be_i[n]) begin
          r_mem[w_idx][8*n +: 8] <= wdata_i[8*n +: 8];
        end
      end
    end
  end

  // Response shift register: stage 0 takes the newly granted request (or a
  // bubble), every stage shifts once per cycle, reset discards everything.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < int'(LATENCY); i++) begin
        r_vld[i] <= 1'b0;
        r_err[i] <= 1'b0;
        r_dat[i] <= 32'h0000_0000;
      end
    end else begin
      r_vld[0] <= w_gnt;
      r_err[0] <= w_gnt & ~w_in_range;
      r_dat[0] <= w_rsp_data;
      for (int i = 1; i < int'(LATENCY); i++) begin
        r_vld[i] <= r_vld[i-1];
        r_err[i] <= r_err[i-1];
        r_dat[i] <= r_dat[i-1];
      end
    end
  end

  assign rvalid_o     = r_vld[LATENCY-1];
  assign err_o        = r_err[LATENCY-1];
  assign rdata_o      = r_dat[LATENCY-1];
  assign rdata_intg_o = 7'b000_0000;

  // Integrity input and sub-word address bits carry no meaning here.
  assign w_unused = ^{wdata_intg_i, addr_i[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_responder
// Description : Self-checking bench for data_mem_responder. Directed steps
//               followed by random traffic, checked against a transaction-
//               level model (word array plus a queue of due responses).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;

  localparam int unsigned c_DEPTH = 1024;
  localparam logic [31:0] c_BASE  = 32'h0000_0000;
  localparam int          c_LAT   = 3;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        req_i = 1'b0;
  logic        gnt_o;
  logic        stall_i = 1'b0;
  logic        we_i = 1'b0;
  logic [3:0]  be_i = 4'h0;
  logic [31:0] addr_i = 32'h0;
  logic [31:0] wdata_i = 32'h0;
  logic [6:0]  wdata_intg_i = 7'h0;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic [6:0]  rdata_intg_o;
  logic        err_o;

  data_mem_responder #(
    .DEPTH_WORDS (c_DEPTH),
    .BASE_ADDR   (c_BASE),
    .LATENCY     (c_LAT)
  ) u_dut (
    .CLK          (CLK),
    .RST          (RST),
    .req_i        (req_i),
    .gnt_o        (gnt_o),
    .stall_i      (stall_i),
    .we_i         (we_i),
    .be_i         (be_i),
    .addr_i       (addr_i),
    .wdata_i      (wdata_i),
    .wdata_intg_i (wdata_intg_i),
    .rvalid_o     (rvalid_o),
    .rdata_o      (rdata_o),
    .rdata_intg_o (rdata_intg_o),
    .err_o        (err_o)
  );

  always #5 CLK = ~CLK;

  // Reference model: word contents and responses scheduled by due cycle.
  typedef struct {
    int          due;
    logic        err;
    logic [31:0] data;
  } rsp_t;

  logic [31:0] m_mem [c_DEPTH];
  rsp_t        m_q [$];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic m_in_range(input logic [31:0] a);
    if (a < c_BASE) return 1'b0;
    return ((a - c_BASE) / 4) < c_DEPTH;
  endfunction

  // Compare every output for the current cycle against the model.
  task automatic check_outputs(input logic exp_gnt);
    logic        e_v;
    logic        e_e;
    logic [31:0] e_d;
    e_v = 1'b0; e_e = 1'b0; e_d = 32'h0;
    if (m_q.size() > 0 && m_q[0].due == cyc) begin
      e_v = 1'b1; e_e = m_q[0].err; e_d = m_q[0].data;
      void'(m_q.pop_front());
    end
    check("gnt_o",    {31'h0, gnt_o},    {31'h0, exp_gnt});
    check("rvalid_o", {31'h0, rvalid_o}, {31'h0, e_v});
    check("err_o",    {31'h0, err_o},    {31'h0, e_e});
    check("rdata_o",  rdata_o,           e_d);
    check("rdata_intg_o", {25'h0, rdata_intg_o}, 32'h0);
  endtask

  // One bus cycle: drive, check mid-cycle, clock, then update the model.
  task automatic step(input logic req, input logic st, input logic we,
                      input logic [3:0] be, input logic [31:0] addr,
                      input logic [31:0] wd);
    logic   g;
    logic   inr;
    int     idx;
    rsp_t   r;
    req_i = req; stall_i = st; we_i = we; be_i = be; addr_i = addr; wdata_i = wd;
    wdata_intg_i = 7'($urandom);
    g = req & ~st;
    @(negedge CLK);
    check_outputs(g);
    @(posedge CLK);
    if (g) begin
      inr    = m_in_range(addr);
      idx    = int'((addr - c_BASE) / 4);
      r.due  = cyc + c_LAT;
      r.err  = ~inr;
      r.data = (!we && inr) ? m_mem[idx] : 32'h0;
      if (we && inr) begin
        for (int n = 0; n < 4; n++)
          if (be[n]) m_mem[idx][8*n +: 8] = wd[8*n +: 8];
      end
      m_q.push_back(r);
    end
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  // Assert reset in the middle of a cycle and hold it across two edges.
  task automatic mid_reset();
    req_i = 1'b1; stall_i = 1'b0; we_i = 1'b0; addr_i = 32'h0;
    @(negedge CLK);
    #2;
    RST = 1'b1;
    #1;
    check("rst rvalid_o", {31'h0, rvalid_o}, 32'h0);
    check("rst err_o",    {31'h0, err_o},    32'h0);
    check("rst rdata_o",  rdata_o,           32'h0);
    check("rst gnt_o",    {31'h0, gnt_o},    32'h0);
    m_q.delete();
    for (int i = 0; i < 2; i++) begin
      @(posedge CLK);
      cyc++;
    end
    @(negedge CLK);
    req_i = 1'b0;
    RST = 1'b0;
    @(posedge CLK);
    cyc++;
    #1;
  endtask

  initial begin
    // Power-on reset with a request already asserted.
    mid_reset();

    // Fill the whole array so every later read has a defined value.
    for (int i = 0; i < int'(c_DEPTH); i++)
      step(1'b1, 1'b0, 1'b1, 4'hF, c_BASE + 32'(i * 4), $urandom);
    idle(c_LAT);

    // Write then read the same word on the next cycle.
    step(1'b1, 1'b0, 1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF);
    step(1'b1, 1'b0, 1'b0, 4'h0, 32'h10, 32'h0);
    idle(c_LAT);

    // Partial byte enables and an all-lanes-off write.
    step(1'b1, 1'b0, 1'b1, 4'hF,    32'h20, 32'h1122_3344);
    step(1'b1, 1'b0, 1'b1, 4'b0101, 32'h20, 32'hAABB_CCDD);
    step(1'b1, 1'b0, 1'b0, 4'h0,    32'h20, 32'h0);
    step(1'b1, 1'b0, 1'b1, 4'h0,    32'h20, 32'hFFFF_FFFF);
    step(1'b1, 1'b0, 1'b0, 4'h3,    32'h20, 32'h0);
    idle(c_LAT);

    // Out-of-range write and read, then confirm word 0 survives.
    step(1'b1, 1'b0, 1'b1, 4'hF, 32'h1000, 32'h5555_AAAA);
    step(1'b1, 1'b0, 1'b0, 4'hF, 32'h1000, 32'h0);
    step(1'b1, 1'b0, 1'b0, 4'hF, 32'h0,    32'h0);
    step(1'b1, 1'b0, 1'b0, 4'hF, 32'hFFFF_FFFC, 32'h0);
    idle(c_LAT);

    // Back-to-back reads, full throughput.
    step(1'b1, 1'b0, 1'b0, 4'hF, 32'h0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 4'hF, 32'h4, 32'h0);
    step(1'b1, 1'b0, 1'b0, 4'hF, 32'h8, 32'h0);
    idle(c_LAT + 1);

    // Backpressure: request held through two stalled cycles.
    step(1'b1, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
    step(1'b1, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
    step(1'b1, 1'b0, 1'b0, 4'hF, 32'h10, 32'h0);
    idle(c_LAT + 1);

    // Reset with two reads in flight: neither response may appear.
    step(1'b1, 1'b0, 1'b0, 4'hF, 32'h0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 4'hF, 32'h4, 32'h0);
    mid_reset();
    idle(c_LAT + 2);

    // Random traffic with occasional out-of-range addresses and stalls.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] a;
      if ($urandom_range(0, 15) == 0) a = 32'h1000 + ($urandom & 32'hFFFF_EFFC);
      else                            a = c_BASE + 32'($urandom_range(0, c_DEPTH - 1) * 4) + 32'($urandom_range(0, 3));
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) == 0),
           1'($urandom), 4'($urandom), a, $urandom);
    end
    idle(c_LAT + 1);

    check("queue drained", 32'(m_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
